// File: rtl/mul_seq_param.sv
// Radix-2 shift-and-add sequential multiplier with optional signed mode.
// Latency tracks the highest set bit of |b|, so small multipliers finish early.
module mul_seq_param #(
  parameter int WIDTH     = 16,
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   a_in,
  input  logic [WIDTH-1:0]   b_in,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  typedef enum logic {IDLE, CALC} state_e;

  state_e             state_q, state_d;
  logic [2*WIDTH-1:0] ma_q, ma_d;
  logic [WIDTH-1:0]   mb_q, mb_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic               neg_q, neg_d;
  logic               done_q, done_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;

  logic               sgn;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [2*WIDTH-1:0] acc_nx;

  assign sgn   = SIGNED_EN & signed_mode;
  // The most negative value negates to itself, which is its correct magnitude.
  assign abs_a = (sgn && a_in[WIDTH-1]) ? -a_in : a_in;
  assign abs_b = (sgn && b_in[WIDTH-1]) ? -b_in : b_in;
  assign acc_nx = acc_q + (mb_q[0] ? ma_q : '0);

  always_comb begin
    state_d = state_q;
    ma_d    = ma_q;
    mb_d    = mb_q;
    acc_d   = acc_q;
    neg_d   = neg_q;
    done_d  = 1'b0;
    prod_d  = prod_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          ma_d    = {{WIDTH{1'b0}}, abs_a};
          mb_d    = abs_b;
          acc_d   = '0;
          neg_d   = sgn & (a_in[WIDTH-1] ^ b_in[WIDTH-1]);
          state_d = CALC;
        end
      end
      CALC: begin
        acc_d = acc_nx;
        ma_d  = ma_q << 1;
        mb_d  = mb_q >> 1;
        if ((mb_q >> 1) == '0) begin
          state_d = IDLE;
          done_d  = 1'b1;
          prod_d  = neg_q ? -acc_nx : acc_nx;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ma_q    <= '0;
      mb_q    <= '0;
      acc_q   <= '0;
      neg_q   <= 1'b0;
      done_q  <= 1'b0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      ma_q    <= ma_d;
      mb_q    <= mb_d;
      acc_q   <= acc_d;
      neg_q   <= neg_d;
      done_q  <= done_d;
      prod_q  <= prod_d;
    end
  end

  assign busy    = (state_q == CALC);
  assign done    = done_q;
  assign product = prod_q;

endmodule

// File: tb/tb_mul_seq_param.sv
// Scoreboard bench for mul_seq_param: signed build (dut0) and
// unsigned-only build (dut1), directed vectors with hand-computed products.
module tb_mul_seq_param;

  typedef struct {
    logic [31:0] p;
    int          n;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start0 = 1'b0, start1 = 1'b0;
  logic        sm0 = 1'b0, sm1 = 1'b0;
  logic [15:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic        busy0, done0, busy1, done1;
  logic [31:0] prod0, prod1;

  exp_t q0[$];
  exp_t q1[$];
  exp_t e0, e1;
  int   bc0 = 0, bc1 = 0;
  int   n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  mul_seq_param #(.WIDTH(16), .SIGNED_EN(1'b1)) dut0 (
    .clk(clk), .reset(reset), .start(start0),
    .signed_mode(sm0), .a_in(a0), .b_in(b0),
    .busy(busy0), .done(done0), .product(prod0)
  );

  mul_seq_param #(.WIDTH(16), .SIGNED_EN(1'b0)) dut1 (
    .clk(clk), .reset(reset), .start(start1),
    .signed_mode(sm1), .a_in(a1), .b_in(b1),
    .busy(busy1), .done(done1), .product(prod1)
  );

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset) bc0 = 0;
    else begin
      if (busy0) bc0++;
      if (done0) begin
        if (q0.size() == 0) chk("spurious_done0", 1, 0);
        else begin
          e0 = q0.pop_front();
          chk("product0", prod0, e0.p);
          chk("calc_cycles0", bc0, e0.n);
          chk("busy_at_done0", busy0, 0);
        end
        bc0 = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (reset) bc1 = 0;
    else begin
      if (busy1) bc1++;
      if (done1) begin
        if (q1.size() == 0) chk("spurious_done1", 1, 0);
        else begin
          e1 = q1.pop_front();
          chk("product1", prod1, e1.p);
          chk("calc_cycles1", bc1, e1.n);
          chk("busy_at_done1", busy1, 0);
        end
        bc1 = 0;
      end
    end
  end

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic issue(input bit sel, input logic [15:0] a,
                       input logic [15:0] b, input bit sm,
                       input logic [31:0] p, input int n);
    exp_t e;
    e.p = p;
    e.n = n;
    if (sel) begin
      a1 = a; b1 = b; sm1 = sm; start1 = 1'b1;
      q1.push_back(e);
    end else begin
      a0 = a; b0 = b; sm0 = sm; start0 = 1'b1;
      q0.push_back(e);
    end
    @(negedge clk);
    start0 = 1'b0;
    start1 = 1'b0;
  endtask

  task automatic wait_done(input bit sel);
    for (int i = 0; i < 40; i++) begin
      if (sel ? done1 : done0) return;
      @(negedge clk);
    end
    chk("done_timeout", 0, 1);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_busy", busy0, 0);
    chk("rst_done", done0, 0);
    chk("rst_product", prod0, 0);
    reset = 1'b0;
    @(negedge clk);

    issue(0, 16'd5, 16'd4, 0, 32'd20, 3);
    chk("busy_after_start", busy0, 1);
    wait_done(0);
    @(negedge clk);
    chk("product_hold", prod0, 32'd20);
    chk("done_one_cycle", done0, 0);

    issue(0, 16'h1234, 16'h0000, 0, 32'h0, 1);
    wait_done(0);
    issue(0, 16'hFFFF, 16'hFFFF, 0, 32'hFFFE0001, 16);
    wait_done(0);

    issue(0, 16'hFFFD, 16'd7, 1, 32'hFFFFFFEB, 3);
    wait_done(0);
    issue(0, 16'h8000, 16'h8000, 1, 32'h40000000, 16);
    wait_done(0);
    issue(0, 16'h8000, 16'h0001, 1, 32'hFFFF8000, 1);
    wait_done(0);
    issue(0, 16'd5, 16'hFFFC, 1, 32'hFFFFFFEC, 3);
    wait_done(0);
    issue(0, 16'h0000, 16'hFFFF, 1, 32'h0, 1);
    wait_done(0);

    issue(0, 16'hFFFD, 16'd7, 0, 32'h0006FFEB, 3);
    wait_done(0);
    issue(1, 16'hFFFD, 16'd7, 1, 32'h0006FFEB, 3);
    wait_done(1);
    issue(1, 16'h8000, 16'h0001, 1, 32'h00008000, 1);
    wait_done(1);

    // Restart and operand changes while busy must be ignored.
    issue(0, 16'd3, 16'd5, 0, 32'd15, 3);
    a0 = 16'd100; b0 = 16'd200; start0 = 1'b1;
    repeat (2) @(negedge clk);
    start0 = 1'b0;
    wait_done(0);
    issue(0, 16'd2, 16'd3, 0, 32'd6, 2);
    chk("start_in_done_cycle", busy0, 1);
    wait_done(0);
    @(negedge clk);

    issue(0, 16'd9, 16'h00F0, 0, 32'd1, 8);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    q0.delete();
    chk("abort_busy", busy0, 0);
    chk("abort_done", done0, 0);
    chk("abort_product", prod0, 0);
    repeat (12) @(negedge clk);
    chk("abort_product_later", prod0, 0);

    issue(0, 16'd6, 16'd7, 0, 32'd42, 3);
    wait_done(0);
    repeat (3) @(negedge clk);
    chk("queue0_drained", q0.size(), 0);
    chk("queue1_drained", q1.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
